ureg_sequencer: RTL

Command-driven controller for the 8-bit universal shift register (HOLD / SHIFT MSB<LSB / PARALLEL LOAD / SHIFT MSB>LSB, sync clear, enable).
- Accepts one command at a time over valid/ready and sequences the register's ctrl, enable, serial-in, parallel-data and clear lines cycle by cycle.
- Supports multi-bit shifts with selectable fill, and emits the shifted-out bit stream.
- Sits between the top-level pin decode and the register instance.

---
 rtl/ureg_seq_pkg.sv | 34 +++
 rtl/ureg_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ureg_seq_pkg.sv
// Shared encodings for the universal-shift-register command sequencer:
// command ops, fill sources, register mode codes and FSM states.
package ureg_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_SHL  = 2'd1,
        OP_SHR  = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_ROT  = 2'd2,
        FILL_EXT  = 2'd3
    } fill_e;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SHL  = 2'd1,
        MODE_LOAD = 2'd2,
        MODE_SHR  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ureg_sequencer.sv
// Command-driven sequencer for an 8-bit universal shift register: accepts one
// LOAD/SHL/SHR/CLEAR command at a time and drives the register lines per cycle.
module ureg_sequencer
    import ureg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [1:0]       cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       reg_ctrl,
    output logic             reg_en,
    output logic             reg_sin,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_clr,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    fill_e            fill_q, fill_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic  cmd_ready_q, busy_q, reg_en_q, reg_clr_q, done_q;
    mode_e reg_ctrl_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fill_d  = fill_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = op_e'(cmd_op);
                    fill_d = fill_e'(cmd_fill);
                    data_d = cmd_data;
                    cnt_d  = (cmd_cnt > CNT_MAX) ? CNT_MAX : cmd_cnt;
                    case (op_e'(cmd_op))
                        OP_LOAD: state_d = ST_LOAD;
                        OP_CLR:  state_d = ST_CLR;
                        default: state_d = (cmd_cnt == '0) ? ST_DONE : ST_SHIFT;
                    endcase
                end
            end
            ST_LOAD, ST_CLR: state_d = ST_DONE;
            // Counter holds the remaining steps including the current one.
            ST_SHIFT: begin
                if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOAD;
            fill_q      <= FILL_ZERO;
            data_q      <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            reg_en_q    <= 1'b0;
            reg_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            reg_ctrl_q  <= MODE_HOLD;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            reg_en_q    <= (state_d == ST_LOAD) || (state_d == ST_SHIFT);
            reg_clr_q   <= (state_d == ST_CLR);
            done_q      <= (state_d == ST_DONE);
            if (state_d == ST_LOAD)
                reg_ctrl_q <= MODE_LOAD;
            else if (state_d == ST_SHIFT)
                reg_ctrl_q <= (op_d == OP_SHL) ? MODE_SHL : MODE_SHR;
            else
                reg_ctrl_q <= MODE_HOLD;
        end
    end

    logic in_shift, out_bit, fill_bit;

    assign in_shift = (state_q == ST_SHIFT);
    assign out_bit  = (op_q == OP_SHL) ? reg_q[WIDTH-1] : reg_q[0];

    // Rotate feeds back exactly the bit that is leaving the register.
    always_comb begin
        fill_bit = 1'b0;
        case (fill_q)
            FILL_ZERO: fill_bit = 1'b0;
            FILL_ONE:  fill_bit = 1'b1;
            FILL_ROT:  fill_bit = out_bit;
            FILL_EXT:  fill_bit = ser_in;
            default:   fill_bit = 1'b0;
        endcase
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign reg_en        = reg_en_q;
    assign reg_clr       = reg_clr_q;
    assign done          = done_q;
    assign reg_ctrl      = reg_ctrl_q;
    assign reg_d         = data_q;
    assign reg_sin       = in_shift & fill_bit;
    assign ser_out       = in_shift & out_bit;
    assign ser_out_valid = in_shift;

endmodule
